// File: rtl/d2e_pkg.sv
// Processor defines shared by the decode-to-execute boundary.
// ALU opcodes, control-word bit order, push/pop, CALL phase, sequencer states.
package d2e_pkg;

  localparam int DATA_W = 16;
  localparam int PC_W   = 32;
  localparam int RA_W   = 3;
  localparam int CTRL_W = 10;
  localparam int ALU_W  = 4;

  // Control word {IR,IW,MR,MW,MTR,ALU_src,RW,Branch,SetC,CLRC}
  localparam int CB_IR   = 9;
  localparam int CB_IW   = 8;
  localparam int CB_MR   = 7;
  localparam int CB_MW   = 6;
  localparam int CB_MTR  = 5;
  localparam int CB_ASRC = 4;
  localparam int CB_RW   = 3;
  localparam int CB_BR   = 2;
  localparam int CB_SETC = 1;
  localparam int CB_CLRC = 0;

  localparam logic [CTRL_W-1:0] ALU_SIGNALS = 10'b00_0000_1000;

  typedef enum logic [ALU_W-1:0] {
    ALU_NOP = 4'd0,
    ALU_ADD = 4'd1,
    ALU_SUB = 4'd2,
    ALU_AND = 4'd3,
    ALU_OR  = 4'd4,
    ALU_NOT = 4'd5,
    ALU_INC = 4'd6,
    ALU_DEC = 4'd7,
    ALU_SHL = 4'd8,
    ALU_SHR = 4'd9,
    ALU_MOV = 4'd10
  } alu_op_e;

  localparam logic [1:0] PP_NONE = 2'b00;
  localparam logic [1:0] PP_PUSH = 2'b01;
  localparam logic [1:0] PP_POP  = 2'b11;

  localparam logic [1:0] CALL_NONE   = 2'b00;
  localparam logic [1:0] CALL_FIRST  = 2'b11;
  localparam logic [1:0] CALL_SECOND = 2'b01;

  typedef enum logic [1:0] {
    S_NORMAL  = 2'd0,
    S_LDM_IMM = 2'd1,
    S_CALL_HI = 2'd2,
    S_DRAIN   = 2'd3
  } seq_state_e;

endpackage

// File: rtl/d2e_seq_fsm.sv
// Multi-cycle sequencer: LDM two-word, CALL two-push, RET/RTI drain.
// Owns state + St/Sst/FlushNum/firstCall feedback; exports load/kill.
module d2e_seq_fsm
  import d2e_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_stall,
  input  logic       i_flush,
  input  logic       i_st,
  input  logic       i_sst,
  input  logic [1:0] i_flush_num,
  input  logic [1:0] i_first_call,
  output logic       o_st,
  output logic       o_sst,
  output logic [1:0] o_flush_num,
  output logic [1:0] o_first_call,
  output seq_state_e o_state,
  output logic       o_load,
  output logic       o_kill
);

  seq_state_e r_state;
  seq_state_e w_next;
  logic       r_st;
  logic       r_sst;
  logic [1:0] r_flush_num;
  logic [1:0] r_first_call;
  logic       w_kill;
  logic       w_load;

  // The CALL caused the redirect, so its second push must survive it.
  assign w_kill = i_flush && (r_state != S_CALL_HI);
  // A flush that is not a kill still advances the pipe.
  assign w_load = i_flush || !i_stall;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_NORMAL: begin
        if (i_st && i_sst)
          w_next = S_LDM_IMM;
        else if (i_first_call == CALL_FIRST)
          w_next = S_CALL_HI;
        else if (i_flush_num != 2'd0)
          w_next = S_DRAIN;
      end
      S_LDM_IMM: w_next = S_NORMAL;
      S_CALL_HI: w_next = S_NORMAL;
      S_DRAIN: begin
        if (i_flush_num == 2'd0)
          w_next = S_NORMAL;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_NORMAL;
      r_st         <= 1'b0;
      r_sst        <= 1'b0;
      r_flush_num  <= 2'd0;
      r_first_call <= CALL_NONE;
    end else if (w_kill) begin
      r_state      <= S_NORMAL;
      r_st         <= 1'b0;
      r_sst        <= 1'b0;
      r_flush_num  <= 2'd0;
      r_first_call <= CALL_NONE;
    end else if (w_load) begin
      r_state      <= w_next;
      r_st         <= i_st;
      r_sst        <= i_sst;
      r_flush_num  <= i_flush_num;
      r_first_call <= i_first_call;
    end
  end

  assign o_st         = r_st;
  assign o_sst        = r_sst;
  assign o_flush_num  = r_flush_num;
  assign o_first_call = r_first_call;
  assign o_state      = r_state;
  assign o_load       = w_load;
  assign o_kill       = w_kill;

endmodule

// File: rtl/d2e_buffer.sv
// Decode-to-execute pipeline register with stall/flush and LDM immediate.
// Ports: control/ALU/data/addr/instr/pc in -> *_q out, seq feedback, bubble_q.
module d2e_buffer
  import d2e_pkg::*;
#(
  parameter int DATA_W = d2e_pkg::DATA_W,
  parameter int PC_W   = d2e_pkg::PC_W,
  parameter int RA_W   = d2e_pkg::RA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic [9:0]        ctrl_in,
  input  logic [3:0]        alu_sig_in,
  input  logic              shift_in,
  input  logic [1:0]        push_pop_in,
  input  logic              st_in,
  input  logic              sst_in,
  input  logic [1:0]        flush_num_in,
  input  logic [1:0]        first_call_in,
  input  logic [DATA_W-1:0] rsrc_data_in,
  input  logic [DATA_W-1:0] rdst_data_in,
  input  logic [RA_W-1:0]   rsrc_addr_in,
  input  logic [RA_W-1:0]   rdst_addr_in,
  input  logic [DATA_W-1:0] instr_in,
  input  logic [PC_W-1:0]   pc_in,
  output logic [9:0]        ctrl_q,
  output logic [3:0]        alu_sig_q,
  output logic              shift_q,
  output logic [1:0]        push_pop_q,
  output logic [DATA_W-1:0] rsrc_data_q,
  output logic [DATA_W-1:0] rdst_data_q,
  output logic [RA_W-1:0]   rsrc_addr_q,
  output logic [RA_W-1:0]   rdst_addr_q,
  output logic [PC_W-1:0]   pc_q,
  output logic [DATA_W-1:0] imm_q,
  output logic              st_q,
  output logic              sst_q,
  output logic [1:0]        flush_num_q,
  output logic [1:0]        first_call_q,
  output logic              bubble_q
);

  seq_state_e w_state;
  logic       w_load;
  logic       w_kill;
  logic       w_ldm;

  logic [9:0]        r_ctrl;
  logic [3:0]        r_alu_sig;
  logic              r_shift;
  logic [1:0]        r_push_pop;
  logic [DATA_W-1:0] r_rsrc_data;
  logic [DATA_W-1:0] r_rdst_data;
  logic [RA_W-1:0]   r_rsrc_addr;
  logic [RA_W-1:0]   r_rdst_addr;
  logic [PC_W-1:0]   r_pc;
  logic [DATA_W-1:0] r_imm;
  logic              r_bubble;

  d2e_seq_fsm u_seq (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_stall      (stall),
    .i_flush      (flush),
    .i_st         (st_in),
    .i_sst        (sst_in),
    .i_flush_num  (flush_num_in),
    .i_first_call (first_call_in),
    .o_st         (st_q),
    .o_sst        (sst_q),
    .o_flush_num  (flush_num_q),
    .o_first_call (first_call_q),
    .o_state      (w_state),
    .o_load       (w_load),
    .o_kill       (w_kill)
  );

  // Second LDM word: keep the LDM's destination, capture the immediate.
  assign w_ldm = (w_state == S_LDM_IMM) && !w_kill;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ctrl      <= '0;
      r_alu_sig   <= '0;
      r_shift     <= 1'b0;
      r_push_pop  <= '0;
      r_rsrc_data <= '0;
      r_rdst_data <= '0;
      r_rsrc_addr <= '0;
      r_rdst_addr <= '0;
      r_pc        <= '0;
      r_imm       <= '0;
      r_bubble    <= 1'b1;
    end else if (w_load) begin
      r_rsrc_data <= rsrc_data_in;
      r_rdst_data <= rdst_data_in;
      r_rsrc_addr <= rsrc_addr_in;
      r_pc        <= pc_in;
      if (!w_ldm)
        r_rdst_addr <= rdst_addr_in;
      if (w_ldm)
        r_imm <= instr_in;
      if (w_kill) begin
        r_ctrl     <= '0;
        r_alu_sig  <= ALU_NOP;
        r_shift    <= 1'b0;
        r_push_pop <= PP_NONE;
        r_bubble   <= 1'b1;
      end else begin
        r_ctrl     <= ctrl_in;
        r_alu_sig  <= alu_sig_in;
        r_shift    <= shift_in;
        r_push_pop <= push_pop_in;
        r_bubble   <= (ctrl_in == '0)
                   && (push_pop_in == PP_NONE);
      end
    end
  end

  assign ctrl_q      = r_ctrl;
  assign alu_sig_q   = r_alu_sig;
  assign shift_q     = r_shift;
  assign push_pop_q  = r_push_pop;
  assign rsrc_data_q = r_rsrc_data;
  assign rdst_data_q = r_rdst_data;
  assign rsrc_addr_q = r_rsrc_addr;
  assign rdst_addr_q = r_rdst_addr;
  assign pc_q        = r_pc;
  assign imm_q       = r_imm;
  assign bubble_q    = r_bubble;

endmodule

// File: tb/tb_d2e_buffer.sv
// Directed self-checking bench for d2e_buffer.
// Drives after posedge+1, checks after the next posedge+1.
module tb_d2e_buffer;
  import d2e_pkg::*;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        flush;
  logic [9:0]  ctrl_in;
  logic [3:0]  alu_sig_in;
  logic        shift_in;
  logic [1:0]  push_pop_in;
  logic        st_in;
  logic        sst_in;
  logic [1:0]  flush_num_in;
  logic [1:0]  first_call_in;
  logic [15:0] rsrc_data_in;
  logic [15:0] rdst_data_in;
  logic [2:0]  rsrc_addr_in;
  logic [2:0]  rdst_addr_in;
  logic [15:0] instr_in;
  logic [31:0] pc_in;
  logic [9:0]  ctrl_q;
  logic [3:0]  alu_sig_q;
  logic        shift_q;
  logic [1:0]  push_pop_q;
  logic [15:0] rsrc_data_q;
  logic [15:0] rdst_data_q;
  logic [2:0]  rsrc_addr_q;
  logic [2:0]  rdst_addr_q;
  logic [31:0] pc_q;
  logic [15:0] imm_q;
  logic        st_q;
  logic        sst_q;
  logic [1:0]  flush_num_q;
  logic [1:0]  first_call_q;
  logic        bubble_q;

  int n_chk;
  int n_err;

  d2e_buffer dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .flush         (flush),
    .ctrl_in       (ctrl_in),
    .alu_sig_in    (alu_sig_in),
    .shift_in      (shift_in),
    .push_pop_in   (push_pop_in),
    .st_in         (st_in),
    .sst_in        (sst_in),
    .flush_num_in  (flush_num_in),
    .first_call_in (first_call_in),
    .rsrc_data_in  (rsrc_data_in),
    .rdst_data_in  (rdst_data_in),
    .rsrc_addr_in  (rsrc_addr_in),
    .rdst_addr_in  (rdst_addr_in),
    .instr_in      (instr_in),
    .pc_in         (pc_in),
    .ctrl_q        (ctrl_q),
    .alu_sig_q     (alu_sig_q),
    .shift_q       (shift_q),
    .push_pop_q    (push_pop_q),
    .rsrc_data_q   (rsrc_data_q),
    .rdst_data_q   (rdst_data_q),
    .rsrc_addr_q   (rsrc_addr_q),
    .rdst_addr_q   (rdst_addr_q),
    .pc_q          (pc_q),
    .imm_q         (imm_q),
    .st_q          (st_q),
    .sst_q         (sst_q),
    .flush_num_q   (flush_num_q),
    .first_call_q  (first_call_q),
    .bubble_q      (bubble_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst           = 1'b0;
    stall         = 1'b0;
    flush         = 1'b0;
    ctrl_in       = '0;
    alu_sig_in    = '0;
    shift_in      = 1'b0;
    push_pop_in   = '0;
    st_in         = 1'b0;
    sst_in        = 1'b0;
    flush_num_in  = '0;
    first_call_in = '0;
    rsrc_data_in  = '0;
    rdst_data_in  = '0;
    rsrc_addr_in  = '0;
    rdst_addr_in  = '0;
    instr_in      = '0;
    pc_in         = '0;
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    idle();
    rst   = 1'b1;
    ctrl_in = ALU_SIGNALS;
    rsrc_data_in = 16'h7777;
    tick();
    chk("rst_ctrl", 32'(ctrl_q), 0);
    chk("rst_rsrc", 32'(rsrc_data_q), 0);
    chk("rst_bub", 32'(bubble_q), 1);
    chk("rst_fc", 32'(first_call_q), 0);

    // ADD
    idle();
    ctrl_in      = ALU_SIGNALS;
    alu_sig_in   = ALU_ADD;
    rsrc_data_in = 16'h0005;
    rdst_data_in = 16'h0003;
    rsrc_addr_in = 3'd1;
    rdst_addr_in = 3'd4;
    pc_in        = 32'h0000_0100;
    tick();
    chk("add_ctrl", 32'(ctrl_q), 32'h008);
    chk("add_alu", 32'(alu_sig_q), 1);
    chk("add_rsrc", 32'(rsrc_data_q), 5);
    chk("add_rdst", 32'(rdst_data_q), 3);
    chk("add_ra", 32'(rsrc_addr_q), 1);
    chk("add_rd", 32'(rdst_addr_q), 4);
    chk("add_pc", 32'(pc_q), 32'h100);
    chk("add_bub", 32'(bubble_q), 0);

    idle();
    tick();
    chk("nop_bub", 32'(bubble_q), 1);

    // LDM R2, 0xBEEF
    idle();
    st_in = 1'b1;
    sst_in = 1'b1;
    rdst_addr_in = 3'd2;
    instr_in = 16'h3A02;
    tick();
    chk("ldm1_st", 32'(st_q), 1);
    chk("ldm1_sst", 32'(sst_q), 1);
    idle();
    ctrl_in = ALU_SIGNALS;
    st_in = 1'b1;
    instr_in = 16'hBEEF;
    rdst_addr_in = 3'd5;
    tick();
    chk("ldm2_imm", 32'(imm_q), 32'hBEEF);
    chk("ldm2_rd", 32'(rdst_addr_q), 2);
    chk("ldm2_rw", 32'(ctrl_q[CB_RW]), 1);
    chk("ldm2_st", 32'(st_q), 1);
    chk("ldm2_sst", 32'(sst_q), 0);
    idle();
    instr_in = 16'h1234;
    rdst_addr_in = 3'd6;
    tick();
    chk("ldm3_imm", 32'(imm_q), 32'hBEEF);
    chk("ldm3_rd", 32'(rdst_addr_q), 6);

    // CALL with two stalled cycles in CALL_HI
    idle();
    first_call_in = CALL_FIRST;
    push_pop_in = PP_PUSH;
    tick();
    chk("call_fc0", 32'(first_call_q), 3);
    chk("call_pp0", 32'(push_pop_q), 1);
    first_call_in = CALL_SECOND;
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("call_stall", 32'(first_call_q), 3);
    end
    stall = 1'b0;
    tick();
    chk("call_fc1", 32'(first_call_q), 1);
    chk("call_pp1", 32'(push_pop_q), 1);
    idle();
    tick();
    chk("call_fc2", 32'(first_call_q), 0);

    // Flush during LDM_IMM
    idle();
    st_in = 1'b1;
    sst_in = 1'b1;
    rdst_addr_in = 3'd4;
    tick();
    idle();
    flush = 1'b1;
    ctrl_in = ALU_SIGNALS;
    alu_sig_in = ALU_SUB;
    push_pop_in = PP_PUSH;
    st_in = 1'b1;
    instr_in = 16'hCAFE;
    rdst_addr_in = 3'd7;
    rsrc_data_in = 16'h4242;
    tick();
    chk("fl_ctrl", 32'(ctrl_q), 0);
    chk("fl_alu", 32'(alu_sig_q), 0);
    chk("fl_pp", 32'(push_pop_q), 0);
    chk("fl_bub", 32'(bubble_q), 1);
    chk("fl_st", 32'(st_q), 0);
    chk("fl_sst", 32'(sst_q), 0);
    chk("fl_rd", 32'(rdst_addr_q), 7);
    chk("fl_rsrc", 32'(rsrc_data_q), 32'h4242);
    chk("fl_imm", 32'(imm_q), 32'hBEEF);
    idle();
    instr_in = 16'h1111;
    rdst_addr_in = 3'd3;
    tick();
    chk("fl_imm2", 32'(imm_q), 32'hBEEF);
    chk("fl_rd2", 32'(rdst_addr_q), 3);

    // Flush during CALL_HI
    idle();
    first_call_in = CALL_FIRST;
    push_pop_in = PP_PUSH;
    tick();
    idle();
    flush = 1'b1;
    stall = 1'b1;
    first_call_in = CALL_SECOND;
    push_pop_in = PP_PUSH;
    ctrl_in = ALU_SIGNALS;
    tick();
    chk("fc_fc", 32'(first_call_q), 1);
    chk("fc_pp", 32'(push_pop_q), 1);
    chk("fc_ctrl", 32'(ctrl_q), 32'h008);
    chk("fc_bub", 32'(bubble_q), 0);
    idle();
    tick();
    chk("fc_fc2", 32'(first_call_q), 0);

    // Flush + stall in NORMAL: flush wins
    idle();
    flush = 1'b1;
    stall = 1'b1;
    ctrl_in = ALU_SIGNALS;
    rsrc_data_in = 16'h9999;
    tick();
    chk("fs_ctrl", 32'(ctrl_q), 0);
    chk("fs_rsrc", 32'(rsrc_data_q), 32'h9999);

    // RET drain 2,1,0 with a stall in between
    idle();
    flush_num_in = 2'd2;
    tick();
    chk("ret_2", 32'(flush_num_q), 2);
    stall = 1'b1;
    flush_num_in = 2'd1;
    tick();
    chk("ret_hold", 32'(flush_num_q), 2);
    stall = 1'b0;
    tick();
    chk("ret_1", 32'(flush_num_q), 1);
    flush_num_in = 2'd0;
    tick();
    chk("ret_0", 32'(flush_num_q), 0);

    // Flush during DRAIN clears the countdown
    flush_num_in = 2'd2;
    tick();
    flush = 1'b1;
    flush_num_in = 2'd1;
    tick();
    chk("dr_fl", 32'(flush_num_q), 0);

    // Reset mid-CALL with stall and flush asserted
    idle();
    first_call_in = CALL_FIRST;
    push_pop_in = PP_PUSH;
    ctrl_in = ALU_SIGNALS;
    rsrc_data_in = 16'h5555;
    pc_in = 32'hABCD;
    tick();
    rst = 1'b1;
    stall = 1'b1;
    flush = 1'b1;
    first_call_in = CALL_SECOND;
    tick();
    chk("rc_fc", 32'(first_call_q), 0);
    chk("rc_pp", 32'(push_pop_q), 0);
    chk("rc_ctrl", 32'(ctrl_q), 0);
    chk("rc_rsrc", 32'(rsrc_data_q), 0);
    chk("rc_pc", 32'(pc_q), 0);
    chk("rc_bub", 32'(bubble_q), 1);
    idle();
    first_call_in = CALL_NONE;
    tick();
    chk("rc_after", 32'(first_call_q), 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/d2e_buffer.md
# d2e_buffer

Decode-to-execute pipeline register of the 16-bit, five-stage processor. Captures the control word from the control unit, the register-file operands, register addresses, instruction word and PC. Feeds the execute stage. Holds the multi-cycle sequencing state that the control unit reads back each cycle: LDM two-word, CALL two-push and RET/RTI flush countdown. Also handles stall (hold) and flush (bubble) requests from the hazard logic.

## Interface
- DATA_W, 16, operand/instruction word width
- PC_W, 32, program counter width
- RA_W, 3, register address width
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- stall  in  1  hold every register (load-use hazard)
- flush  in  1  replace captured instruction with a bubble (taken branch in execute)
- ctrl_in  in  10  {IR,IW,MR,MW,MTR,ALU_src,RW,Branch,SetC,CLRC}
- alu_sig_in  in  4  ALU opcode; shift_in in 1; push_pop_in in 2 (00 none, 01 push, 11 pop)
- st_in, sst_in  in  1 each  LDM sequencing from control unit
- flush_num_in  in  2  remaining RET/RTI bubbles
- first_call_in  in  2  CALL phase (00 none, 11 first push, 01 second push)
- rsrc_data_in, rdst_data_in  in  DATA_W  register operands
- rsrc_addr_in, rdst_addr_in  in  RA_W  register addresses
- instr_in  in  DATA_W  current decode instruction word
- pc_in  in  PC_W  PC of the instruction in decode
- ctrl_q, alu_sig_q, shift_q, push_pop_q, rsrc_data_q, rdst_data_q, rsrc_addr_q, rdst_addr_q, pc_q  out  same widths  registered copies
- imm_q  out  DATA_W  LDM immediate
- st_q, sst_q, flush_num_q, first_call_q  out  1/1/2/2  feedback to control unit
- bubble_q  out  1  execute stage holds no architectural instruction

## Operation
- Update priority per edge: rst > flush > stall > normal load.
- Reset: every output 0, bubble_q=1, state NORMAL.
- Sequencer states and transitions:
  - NORMAL: on load with st_in=1 and sst_in=1, go to LDM_IMM. On first_call_in=11, go to CALL_HI. On flush_num_in>0, go to DRAIN.
  - LDM_IMM: next load sets imm_q<=instr_in, holds rdst_addr_q from the LDM word, then returns to NORMAL.
  - CALL_HI: next load captures the control unit's second-push word (first_call_in=01), then returns to NORMAL.
  - DRAIN: stays while flush_num_in>0 and returns to NORMAL at 0. The countdown itself comes from the control unit. This block only registers it.
- Normal load: all *_q take their *_in values, and bubble_q = (ctrl_in==0 and push_pop_in==0).
- Stall: all registers and the state hold, including feedback outputs. The control unit therefore sees an unchanged St/Sst/FlushNum/firstTimeCall.
- Flush in NORMAL, LDM_IMM or DRAIN:
  - ctrl_q, push_pop_q, shift_q and alu_sig_q go to 0 (ALU NOP), and bubble_q=1.
  - st_q, sst_q, flush_num_q and first_call_q go to 0, and state goes to NORMAL. This aborts a pending LDM or drain.
  - Data, address and pc registers still load.
- Flush in CALL_HI is ignored for first_call_q/state. The call's second push must complete, and the CALL itself caused the redirect. The control/data registers still load normally so the push proceeds.
- flush and stall together: flush wins.
- No arithmetic. flush_num is passed through unmodified, and wrap is impossible because the control unit never decrements below 0.

## Timing
- Latency is exactly 1 cycle from *_in to *_q when not stalled.
- Feedback outputs reach the control unit combinationally in the same cycle as the execute stage sees the word.
- LDM: cycle N decode LDM gives st_q=sst_q=1 at N+1. Cycle N+1 decode the immediate gives imm_q valid and ctrl_q with RW=1 at N+2.
- CALL: first_call_q=11 at N+1 and 01 at N+2, then 00.
- A stall during LDM_IMM/CALL_HI extends that state by one cycle per stalled cycle.
- Reset asserted mid-sequence clears it at the next edge. There is no partial-state retention.

## Structure
- Shared package (processor defines): ALU opcodes, the 10-bit control-word bit order, push/pop and CALL-phase encodings, and the sequencer state enum {NORMAL, LDM_IMM, CALL_HI, DRAIN}.
- One natural sub-module: d2e_seq_fsm, which owns the state and feedback registers. The datapath register bank stays in d2e_buffer.

## Test plan
- Load ADD word ctrl=`ALU_SIGNALS`, rsrc=0x0005, rdst=0x0003 → next cycle ctrl_q/alu_sig_q match, data_q=0x0005/0x0003, bubble_q=0.
- LDM R2 then instr_in=0xBEEF → st_q=sst_q=1 after 1 cycle, then imm_q=0xBEEF, rdst_addr_q=2, RW=1, and st_q=1, sst_q=0.
- CALL with stall held 2 cycles in CALL_HI → first_call_q stays 11 for 3 cycles, then 01, then 00. push_pop_q=01 in both phases.
- Flush during LDM_IMM → ctrl_q=0, bubble_q=1, st_q=sst_q=0, state NORMAL. Flush during CALL_HI → first_call_q still goes 01.
- RET (flush_num_in=2, then 1, then 0) → flush_num_q follows 2,1,0 one cycle later. State returns to NORMAL when it reads 0.
- rst asserted with stall=1 and flush=1 mid-CALL → all outputs 0 and bubble_q=1 after one edge.
